// File: rtl/simon_rkey_if.sv
// Round-key stream between simon_rkey_rev and the inverse round datapath.
//   rk_valid : source holds a round key on rk_out
//   rk_ready : sink accepts rk_out when rk_valid & rk_ready
//   rk_out   : 16-bit round key
//   rk_idx   : index of rk_out (31 down to 0)
//   rk_last  : marks the final key (rk_idx == 0)
interface simon_rkey_if;
  logic        rk_valid;
  logic        rk_ready;
  logic [15:0] rk_out;
  logic [4:0]  rk_idx;
  logic        rk_last;

  modport master (output rk_valid, rk_out, rk_idx, rk_last, input rk_ready);
  modport slave  (input rk_valid, rk_out, rk_idx, rk_last, output rk_ready);
endinterface

// File: rtl/simon_rkey_rev.sv
// Decryption-side round-key source for Simon32/64.
// Loads the 64-bit master key, expands the schedule forward NROUNDS-4 steps
// so that a 4-word window holds the last four round keys, then walks the
// schedule backwards, streaming k31..k0 over the rk stream interface.
// Only the 4-word window is stored; earlier keys are recomputed by the
// inverse step on each handshake.
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   key_in       : master key, [15:0]=k0 .. [63:48]=k3
//   start        : load key_in and begin; sampled only in IDLE
//   busy         : high from the start-accept edge until done
//   done         : one-cycle pulse after k0 is accepted
//   err          : sticky self-check failure (0 unless feature enabled)
//   rk           : round-key stream (master side)
// Optional feature: define SIMON_RKEY_SELFCHECK_EN to latch key_in at start
// and compare the regenerated k3..k0 against it; err is tied 0 otherwise.
module simon_rkey_rev #(
  parameter logic [61:0] Z_CONST = 62'h3E8958737D12B0E6,
  parameter logic [15:0] C_CONST = 16'hFFFC,
  parameter int          NROUNDS = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [63:0]        key_in,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  simon_rkey_if.master       rk
);

  localparam int NSTEPS = NROUNDS - 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, EMIT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0][15:0] win_q, win_d;     // {w3,w2,w1,w0}
  logic [4:0]       step_q, step_d;
  logic [4:0]       idx_q, idx_d;
  logic             done_q, done_d;

  function automatic logic [15:0] ror1(input logic [15:0] x);
    return {x[0], x[15:1]};
  endfunction

  function automatic logic [15:0] ror3(input logic [15:0] x);
    return {x[2:0], x[15:3]};
  endfunction

  // z bit i is taken MSB-first from the constant
  function automatic logic zbit(input logic [4:0] i);
    logic [61:0] zc;
    zc = Z_CONST;
    return zc[6'd61 - {1'b0, i}];
  endfunction

  logic [15:0] t, f, u, g;
  logic [4:0]  zidx;
  logic        emit, hs;

  assign emit = (state_q == EMIT);
  assign hs   = emit & rk.rk_ready;

  // forward step: next key from the oldest word
  assign t = ror3(win_q[3]) ^ win_q[1];
  assign f = C_CONST ^ {15'd0, zbit(step_q)} ^ win_q[0] ^ t ^ ror1(t);

  // inverse step: the same relation solved for k[idx-4]
  assign zidx = (idx_q >= 5'd4) ? idx_q - 5'd4 : 5'd0;
  assign u    = ror3(win_q[2]) ^ win_q[0];
  assign g    = win_q[3] ^ C_CONST ^ {15'd0, zbit(zidx)} ^ u ^ ror1(u);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    step_d  = step_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          win_d   = key_in;
          step_d  = 5'd0;
          idx_d   = 5'd0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        win_d  = {f, win_q[3], win_q[2], win_q[1]};
        step_d = step_q + 5'd1;
        if (step_q == 5'(NSTEPS - 1)) begin
          state_d = EMIT;
          idx_d   = 5'(NROUNDS - 1);
          step_d  = 5'd0;
        end
      end
      EMIT: begin
        if (rk.rk_ready) begin
          // below idx 4 the window just drains; the zeros are never emitted
          if (idx_q >= 5'd4) win_d = {win_q[2], win_q[1], win_q[0], g};
          else               win_d = {win_q[2], win_q[1], win_q[0], 16'h0};
          if (idx_q == 5'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q - 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign rk.rk_valid = emit;
  assign rk.rk_out   = emit ? win_q[3] : 16'h0;
  assign rk.rk_idx   = idx_q;
  assign rk.rk_last  = emit & (idx_q == 5'd0);

`ifdef SIMON_RKEY_SELFCHECK_EN
  // k3..k0 regenerated by the inverse walk must equal the loaded key words
  logic [3:0][15:0] key_q, key_d;
  logic             err_q, err_d;

  always_comb begin
    key_d = key_q;
    err_d = err_q;
    if (state_q == IDLE && start) begin
      key_d = key_in;
      err_d = 1'b0;
    end else if (hs && idx_q < 5'd4 && win_q[3] != key_q[idx_q[1:0]]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= '0;
      err_q <= 1'b0;
    end else begin
      key_q <= key_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_simon_rkey_rev.sv
module tb_simon_rkey_rev;
  localparam logic [61:0] ZC = 62'h3E8958737D12B0E6;
  localparam logic [15:0] CC = 16'hFFFC;
  localparam logic [63:0] KEY_STD = 64'h1918111009080100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] key_in = '0;
  logic        start = 1'b0;
  logic        busy, done, err;

  simon_rkey_if rif();

  simon_rkey_rev dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .start(start),
    .busy(busy), .done(done), .err(err), .rk(rif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_k [32];
  logic [15:0] got_k [32];
  logic [4:0]  got_i [32];
  int n_got, last_cnt, last_pos, done_cnt, stall_bad, busy_bad, lat;
  bit tmo;

  function automatic logic [15:0] r1(input logic [15:0] x); return {x[0], x[15:1]}; endfunction
  function automatic logic [15:0] r3(input logic [15:0] x); return {x[2:0], x[15:3]}; endfunction

  // forward Simon32/64 key schedule
  function automatic void model(input logic [63:0] key);
    logic [15:0] tt;
    for (int i = 0; i < 4; i++) exp_k[i] = key[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      tt = r3(exp_k[i+3]) ^ exp_k[i+1];
      exp_k[i+4] = CC ^ {15'd0, ZC[61-i]} ^ exp_k[i] ^ tt ^ r1(tt);
    end
  endfunction

  // drives one start and collects the 32 accepted keys; mode 0: ready held, 1: random
  task automatic run_seq(input logic [63:0] key, input int mode, input bit repulse, input bit linger);
    int cyc;
    bit pv;
    logic [15:0] po;
    logic [4:0]  pi;
    n_got = 0; last_cnt = 0; last_pos = -1; done_cnt = 0;
    stall_bad = 0; busy_bad = 0; lat = -1; tmo = 0;
    key_in = key; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; pv = 0; po = '0; pi = '0;
    while (n_got < 32 && cyc < 2000) begin
      if (rif.rk_valid && lat < 0) lat = cyc;
      if (pv && (!rif.rk_valid || rif.rk_out !== po || rif.rk_idx !== pi)) stall_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (done) done_cnt++;
      start = repulse && (cyc == 10 || n_got == 5);
      rif.rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rif.rk_valid && rif.rk_ready) begin
        got_k[n_got] = rif.rk_out;
        got_i[n_got] = rif.rk_idx;
        if (rif.rk_last) begin last_cnt++; last_pos = n_got; end
        n_got++;
      end
      pv = rif.rk_valid && !rif.rk_ready;
      po = rif.rk_out; pi = rif.rk_idx;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (n_got < 32) tmo = 1;
    if (linger) begin
      repeat (4) begin
        if (done) done_cnt++;
        @(negedge clk);
      end
    end else if (done) done_cnt++;
  endtask

  task automatic test_reset();
    checks++;
    if ({rif.rk_valid, rif.rk_out, rif.rk_idx, rif.rk_last} !== 23'd0) begin
      failures++; $display("FAIL reset_stream got=%h want=0", {rif.rk_valid, rif.rk_out, rif.rk_idx, rif.rk_last});
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      failures++; $display("FAIL reset_status got=%b want=000", {busy, done, err});
    end
  endtask

  task automatic test_full_stream();
    model(KEY_STD);
    rif.rk_ready = 1'b1;
    run_seq(KEY_STD, 0, 0, 1);
    checks++; if (tmo) begin failures++; $display("FAIL full_timeout got=%0d keys want=32", n_got); end
    checks++; if (lat != 28) begin failures++; $display("FAIL full_latency got=%0d want=28", lat); end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (got_k[n] !== exp_k[31-n] || got_i[n] !== 5'(31-n)) begin
        failures++; $display("FAIL full_key n=%0d got=%h/%0d want=%h/%0d", n, got_k[n], got_i[n], exp_k[31-n], 31-n);
      end
    end
    checks++;
    if ({got_k[28], got_k[29], got_k[30], got_k[31]} !== 64'h1918111009080100) begin
      failures++; $display("FAIL full_last4 got=%h %h %h %h want=1918 1110 0908 0100", got_k[28], got_k[29], got_k[30], got_k[31]);
    end
    checks++; if (got_k[27] !== 16'h71C3) begin failures++; $display("FAIL full_k4 got=%h want=71c3", got_k[27]); end
    checks++; if (last_cnt != 1 || last_pos != 31) begin failures++; $display("FAIL full_last got=%0d@%0d want=1@31", last_cnt, last_pos); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done got=%0d want=1", done_cnt); end
    checks++; if (busy_bad != 0 || busy !== 1'b0) begin failures++; $display("FAIL full_busy got=%0d/%b want=0/0", busy_bad, busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL full_err got=%b want=0", err); end
  endtask

  task automatic test_stall_random();
    model(KEY_STD);
    run_seq(KEY_STD, 1, 0, 1);
    checks++; if (tmo) begin failures++; $display("FAIL stall_timeout got=%0d want=32", n_got); end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (got_k[n] !== exp_k[31-n] || got_i[n] !== 5'(31-n)) begin
        failures++; $display("FAIL stall_key n=%0d got=%h/%0d want=%h/%0d", n, got_k[n], got_i[n], exp_k[31-n], 31-n);
      end
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_stable got=%0d changes want=0", stall_bad); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL stall_err got=%b want=0", err); end
  endtask

  task automatic test_start_ignored();
    model(KEY_STD);
    run_seq(KEY_STD, 1, 1, 1);
    checks++; if (tmo) begin failures++; $display("FAIL restart_timeout got=%0d want=32", n_got); end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (got_k[n] !== exp_k[31-n]) begin
        failures++; $display("FAIL restart_key n=%0d got=%h want=%h", n, got_k[n], exp_k[31-n]);
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL restart_done got=%0d want=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL restart_idle got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    key_in = KEY_STD; rif.rk_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(rif.rk_valid && rif.rk_idx == 5'd17) && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (cyc >= 200) begin failures++; $display("FAIL rstmid_reach got=timeout want=idx17"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rif.rk_valid, rif.rk_out, rif.rk_idx, rif.rk_last, busy, done, err} !== 26'd0) begin
      failures++; $display("FAIL rstmid_outputs got=%h want=0", {rif.rk_valid, rif.rk_out, rif.rk_idx, rif.rk_last, busy, done, err});
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b want=0", done); end
    reset_n = 1'b1;
    @(negedge clk);
    model(64'h0);
    run_seq(64'h0, 0, 0, 1);
    checks++; if (tmo) begin failures++; $display("FAIL rstmid_timeout got=%0d want=32", n_got); end
    checks++;
    if ({got_k[28], got_k[29], got_k[30], got_k[31]} !== 64'h0) begin
      failures++; $display("FAIL rstmid_last4 got=%h %h %h %h want=0", got_k[28], got_k[29], got_k[30], got_k[31]);
    end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (got_k[n] !== exp_k[31-n]) begin
        failures++; $display("FAIL rstmid_key n=%0d got=%h want=%h", n, got_k[n], exp_k[31-n]);
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rstmid_done_cnt got=%0d want=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ka, kb;
    ka = 64'h0123456789ABCDEF;
    kb = 64'hFEDCBA9876543210;
    rif.rk_ready = 1'b1;
    model(ka);
    run_seq(ka, 0, 0, 0);
    checks++; if (tmo || done_cnt != 1) begin failures++; $display("FAIL b2b_a_end got=%0d keys done=%0d want=32/1", n_got, done_cnt); end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (got_k[n] !== exp_k[31-n]) begin
        failures++; $display("FAIL b2b_a_key n=%0d got=%h want=%h", n, got_k[n], exp_k[31-n]);
      end
    end
    model(kb);
    run_seq(kb, 1, 0, 1);
    checks++; if (tmo || done_cnt != 1) begin failures++; $display("FAIL b2b_b_end got=%0d keys done=%0d want=32/1", n_got, done_cnt); end
    checks++; if (lat != 28) begin failures++; $display("FAIL b2b_b_latency got=%0d want=28", lat); end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (got_k[n] !== exp_k[31-n]) begin
        failures++; $display("FAIL b2b_b_key n=%0d got=%h want=%h", n, got_k[n], exp_k[31-n]);
      end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b want=0", err); end
  endtask

`ifdef SIMON_RKEY_SELFCHECK_EN
  task automatic test_selfcheck();
    int cyc;
    logic [3:0][15:0] tmpw;
    rif.rk_ready = 1'b1; key_in = KEY_STD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(rif.rk_valid && rif.rk_idx == 5'd4) && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (cyc >= 200) begin failures++; $display("FAIL sc_reach got=timeout want=idx4"); end
    tmpw = dut.win_q;
    tmpw[0][0] = ~tmpw[0][0];
    force dut.win_q = tmpw;
    #1;
    release dut.win_q;
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL sc_err_set got=%b want=1", err); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL sc_err_hold got=%b want=1", err); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL sc_err_clear got=%b want=0", err); end
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (cyc >= 100 || err !== 1'b0) begin failures++; $display("FAIL sc_clean_run got=%b/%0d want=0", err, cyc); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rif.rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_stream();
    test_stall_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef SIMON_RKEY_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=stuck want=finish");
    $fatal(1, "timeout");
  end
endmodule
